// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between the
// instruction-fetch port and the data (load/store) port. One access is in flight
// at a time; per-port stall outputs let the core freeze while it is outstanding.
// A response timeout force-completes a hung access and sets a sticky err flag.
//
// Build option: define MEM_ARB_RR_EN to break D/I ties round-robin instead of
// using fixed data-over-instruction priority.
module mem_arbiter #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hlt,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_valid,
    output logic          err
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIWait = 2'd1,
        StDWait = 2'd2
    } state_e;

    // Counter value at the edge where the wait has lasted TIMEOUT cycles.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          err_q, err_d;

    logic          i_req_new;
    logic          d_req_new;
    logic          grant_i;
    logic          grant_d;

    // A request still high during its own done pulse is the one just served,
    // not a new one; it only counts again from the following cycle.
    assign i_req_new = i_req & ~i_done_q;
    assign d_req_new = d_req & ~d_done_q;

`ifdef MEM_ARB_RR_EN
    // 1 = last grant went to D. Reset value 0 lets D win the first tie.
    logic last_d_q, last_d_d;

    // Arbitrate: on a tie, grant the port not granted last.
    always_comb begin
        grant_d = d_req_new & (~i_req_new | ~last_d_q);
        grant_i = i_req_new & ~grant_d;
    end

    // Last-grant register, updated at every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    // Arbitrate: fixed priority, the older (data) access in the pipeline first.
    always_comb begin
        grant_d = d_req_new;
        grant_i = i_req_new & ~d_req_new;
    end
`endif

    // Next-state logic: grant in idle, wait for completion or timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        err_d       = err_q;
`ifdef MEM_ARB_RR_EN
        last_d_d    = last_d_q;
`endif

        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (!hlt) begin
                    if (grant_d) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        state_d     = StDWait;
`ifdef MEM_ARB_RR_EN
                        last_d_d    = 1'b1;
`endif
                    end else if (grant_i) begin
                        mem_en_d   = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = i_addr;
                        state_d    = StIWait;
`ifdef MEM_ARB_RR_EN
                        last_d_d   = 1'b0;
`endif
                    end
                end
            end

            StIWait: begin
                cnt_d = 8'(cnt_q + 8'd1);
                // A response on the timeout edge still counts as a normal completion.
                if (mem_valid) begin
                    i_rdata_d = mem_rdata;
                    i_done_d  = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    i_rdata_d = '0;
                    i_done_d  = 1'b1;
                    err_d     = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = StIdle;
                end
            end

            StDWait: begin
                cnt_d = 8'(cnt_q + 8'd1);
                if (mem_valid) begin
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_done_d = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    if (!mem_we_q) begin
                        d_rdata_d = '0;
                    end
                    d_done_d = 1'b1;
                    err_d    = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = StIdle;
                end
            end

            default: begin
                cnt_d   = 8'd0;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
        end
    end

    // Stalls: only combinational paths, from requests and registered done pulses.
    always_comb begin
        i_stall = i_req & ~i_done_q;
        d_stall = d_req & ~d_done_q;
    end

    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT = 8): a table of single accesses with
// hand-computed results, then hand-written tie, halt and reset sequences.
module tb_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hlt;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          i_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic          err;

    int n_checks = 0;
    int n_err    = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hlt       (hlt),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_stall   (d_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    // lat: cycles after the mem_en cycle that mem_valid pulses (0 = never).
    // done_at: cycles after the mem_en cycle that x_done is seen.
    typedef struct {
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mrdata;
        int          lat;
        int          done_at;
        logic [15:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait (bounded) until mem_en is seen on a falling edge.
    task automatic wait_en(input string name);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (mem_en === 1'b1) break;
        end
        chk(name, mem_en, 1);
    endtask

    // Pulse mem_valid for one cycle; returns just after the edge that sampled it.
    task automatic pulse_valid(input logic [15:0] rd);
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_rdata = rd;
        @(posedge clk); #1;
        mem_valid = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        int  k;
        bit  held;
        bit  extra_en;
        bit  stall_ok;
        bit  other_done;
        @(posedge clk); #1;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        @(negedge clk);
        chk("stall_on_req", v.is_d ? d_stall : i_stall, 1);
        chk("no_en_same_cycle", mem_en, 0);
        wait_en("txn_mem_en");
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_we", mem_we, v.is_d ? v.we : 1'b0);
        if (v.is_d && v.we) chk("mem_wdata", mem_wdata, v.wdata);
        k = 0; held = 1; extra_en = 0; stall_ok = 1; other_done = 0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk); #1;
            mem_valid = (v.lat != 0 && j == v.lat);
            mem_rdata = v.mrdata;
            @(negedge clk);
            if ((v.is_d ? i_done : d_done) === 1'b1) other_done = 1;
            if ((v.is_d ? d_done : i_done) === 1'b1) begin
                k = j;
                break;
            end
            if (mem_en !== 1'b0) extra_en = 1;
            if (mem_addr !== v.addr || mem_we !== (v.is_d ? v.we : 1'b0)) held = 0;
            if (v.is_d && v.we && mem_wdata !== v.wdata) held = 0;
            if ((v.is_d ? d_stall : i_stall) !== 1'b1) stall_ok = 0;
        end
        mem_valid = 1'b0;
        chk("done_cycle", k, v.done_at);
        chk("cmd_held", held, 1);
        chk("mem_en_one_cycle", extra_en, 0);
        chk("stall_held", stall_ok, 1);
        chk("other_done_quiet", other_done, 0);
        chk("rdata", v.is_d ? d_rdata : i_rdata, v.exp_rdata);
        chk("err", err, v.exp_err);
        chk("stall_low_at_done", v.is_d ? d_stall : i_stall, 0);
        @(posedge clk); #1;
        if (v.is_d) d_req = 1'b0; else i_req = 1'b0;
        @(negedge clk);
        chk("done_single_pulse", v.is_d ? d_done : i_done, 0);
        chk("no_regrant", mem_en, 0);
    endtask

    initial begin
        logic [15:0] first_addr;
        logic [15:0] second_addr;
        bit          first_is_d;
        bit          bad;

        rst_n = 1'b0; hlt = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_valid = 1'b0;

        //           is_d we  addr      wdata     mrdata    lat dn  exp_rdata err
        tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 3, 4, 16'hA5A5, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 16'hFFFF, 2, 3, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 16'hC0DE, 7, 8, 16'hC0DE, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h3C3C, 1, 2, 16'h3C3C, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 16'h0030, 16'h0000, 16'hDEAD, 0, 8, 16'h0000, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 5, 6, 16'hBEEF, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 16'h0210, 16'h5678, 16'h9999, 0, 8, 16'hC0DE, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 16'h0070, 16'h0000, 16'h4242, 2, 3, 16'h4242, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {mem_en, mem_we, i_done, d_done, err, i_stall, d_stall}, 0);
        chk("rst_data", {i_rdata, d_rdata}, 0);
        chk("rst_mem_bus", {mem_addr, mem_wdata}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int t = 0; t < 7; t++) do_txn(tbl[t]);

        // Tie: both ports request together; last grant so far was D.
`ifdef MEM_ARB_RR_EN
        first_is_d = 1'b0;
`else
        first_is_d = 1'b1;
`endif
        first_addr  = first_is_d ? 16'h0500 : 16'h0050;
        second_addr = first_is_d ? 16'h0050 : 16'h0500;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 16'h0050;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500;
        wait_en("tie_first_en");
        chk("tie_first_addr", mem_addr, first_addr);
        chk("tie_loser_stall", first_is_d ? i_stall : d_stall, 1);
        pulse_valid(16'h1111);
        @(negedge clk);
        chk("tie_first_done", first_is_d ? d_done : i_done, 1);
        chk("tie_second_not_done", first_is_d ? i_done : d_done, 0);
        chk("tie_first_rdata", first_is_d ? d_rdata : i_rdata, 16'h1111);
        @(posedge clk); #1;
        if (first_is_d) d_req = 1'b0; else i_req = 1'b0;
        wait_en("tie_second_en");
        chk("tie_second_addr", mem_addr, second_addr);
        pulse_valid(16'h2222);
        @(negedge clk);
        chk("tie_second_done", first_is_d ? i_done : d_done, 1);
        chk("tie_second_rdata", first_is_d ? i_rdata : d_rdata, 16'h2222);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;

        // Halt blocks new grants but not an outstanding access.
        @(posedge clk); #1;
        hlt = 1'b1; i_req = 1'b1; i_addr = 16'h0060;
        bad = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (mem_en !== 1'b0) bad = 1;
        end
        chk("hlt_no_grant", bad, 0);
        chk("hlt_i_stall", i_stall, 1);
        @(posedge clk); #1;
        hlt = 1'b0;
        wait_en("hlt_release_en");
        chk("hlt_addr", mem_addr, 16'h0060);
        @(posedge clk); #1;
        hlt = 1'b1;
        pulse_valid(16'h6060);
        @(negedge clk);
        chk("hlt_wait_done", i_done, 1);
        chk("hlt_wait_rdata", i_rdata, 16'h6060);
        @(posedge clk); #1;
        i_req = 1'b0; hlt = 1'b0;

        // Asynchronous reset in the middle of a data write, then a stale response.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0600; d_wdata = 16'h7777;
        wait_en("rst_mid_en");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {mem_en, mem_we, d_done, i_done, err}, 0);
        chk("rst_mid_bus", {mem_addr, mem_wdata}, 0);
        chk("rst_mid_rdata", {i_rdata, d_rdata}, 0);
        d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_valid(16'hABCD);
        bad = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if ({mem_en, d_done, i_done, err} !== 4'b0) bad = 1;
            if ({d_rdata, i_rdata, mem_addr} !== 48'b0) bad = 1;
        end
        chk("stale_valid_ignored", bad, 0);

        do_txn(tbl[7]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Sits between the CPU core (fetch and MEM stage) and the memory. It sequences one access at a time, returns read data and raises per-port stall signals so the core can freeze its pipeline registers while an access is outstanding.
- Includes a response timeout with a sticky error flag.

Parameters:
- AW, 16, address width in bits.
- DW, 16, data width in bits.
- TIMEOUT, 255, cycles to wait for mem_valid before force-completing an access (1..255; counter is 8 bits).

Ports:
- clk  input  1  global clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- hlt  input  1  core halted; no new grants while high
- i_req  input  1  instruction read request
- i_addr  input  AW  instruction address
- i_rdata  output  DW  registered instruction read data
- i_done  output  1  one-cycle pulse: instruction access complete
- i_stall  output  1  fetch must hold (i_req & ~i_done)
- d_req  input  1  data access request
- d_we  input  1  1 = write, 0 = read
- d_addr  input  AW  data address
- d_wdata  input  DW  store data
- d_rdata  output  DW  registered load data
- d_done  output  1  one-cycle pulse: data access complete
- d_stall  output  1  MEM stage must hold (d_req & ~d_done)
- mem_en  output  1  one-cycle command strobe to memory
- mem_we  output  1  write qualifier for mem_en
- mem_addr  output  AW  memory address, held for the whole access
- mem_wdata  output  DW  memory write data, held for the whole access
- mem_rdata  input  DW  memory read data, valid with mem_valid
- mem_valid  input  1  one-cycle pulse: memory completed the current command
- err  output  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State goes to IDLE.
  - All outputs are 0, including i_rdata, d_rdata, mem_addr, mem_wdata and err.
  - Wait counter is 0.
  - Round-robin pointer (if compiled in) is 0.
- FSM states:
  - IDLE: waiting for a request.
  - IWAIT: instruction access outstanding.
  - DWAIT: data access outstanding.
- IDLE transitions (taken on the clock edge):
  - hlt=1: no grant; stay in IDLE.
  - d_req=1: grant D. Register mem_addr=d_addr, mem_we=d_we and mem_wdata=d_wdata. Pulse mem_en for 1 cycle. Go to DWAIT.
  - d_req=0 and i_req=1: grant I. Register mem_addr=i_addr and mem_we=0. Pulse mem_en. Go to IWAIT.
  - Otherwise stay in IDLE.
- Default priority is data over instruction, because the older instruction in the pipeline is served first.
- xWAIT behaviour:
  - The wait counter increments every cycle.
  - On mem_valid, the access completes:
    - Read: the matching x_rdata <= mem_rdata.
    - Write: d_rdata is unchanged.
    - x_done pulses in the next cycle.
    - Counter is cleared; go to IDLE.
  - If the counter reaches TIMEOUT with no mem_valid, the access is force-completed:
    - x_rdata <= 0 (reads only); x_done pulses.
    - err <= 1 and stays set until reset.
    - Go to IDLE.
  - A mem_valid in the same cycle as the timeout takes precedence: normal completion, err is not set.
- Latency: the mem_en pulse is 1 cycle after the request is seen in IDLE. x_done is 1 cycle after mem_valid. x_done and the return to IDLE happen in the same cycle, so the next grant can issue in the cycle after x_done.
- mem_addr, mem_we and mem_wdata are held from grant until completion. mem_en is high for exactly one cycle per access.
- Requester rules:
  - x_req and the address/data must stay stable until x_done.
  - Deasserting a request mid-access is illegal. The arbiter completes the access regardless and still pulses x_done.
  - A requester whose req is still high in the cycle after x_done is treated as a new request.
- mem_valid in IDLE, or for a command not outstanding, is ignored.
- Asynchronous reset mid-access: the access is abandoned and no x_done is produced. A later stale mem_valid arrives in IDLE and is ignored.
- hlt rising during WAIT does not abort; the outstanding access completes normally.
- i_stall and d_stall are combinational from the inputs and the registered done pulses. No other combinational path runs from mem_* inputs to outputs.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: when both d_req and i_req are high in IDLE, the grant goes to the port not granted last, tracked by a 1-bit last-grant register updated at each grant. A lone request is granted immediately.
- Undefined: fixed priority, D over I, as above. There is no last-grant register.

Test Plan:
- i_req=1, i_addr=16'h0010, memory returns mem_rdata=16'hA5A5 3 cycles after mem_en -> one mem_en pulse with mem_we=0 and mem_addr=16'h0010; i_rdata=16'hA5A5; i_done is a single pulse 1 cycle after mem_valid; i_stall is high from the request until i_done.
- d_req=1, d_we=1, d_addr=16'h0200, d_wdata=16'h1234 -> mem_we=1 and mem_wdata=16'h1234 held until mem_valid; d_done pulses; d_rdata is unchanged (0).
- i_req and d_req both raised in the same cycle -> D is served first, then I. With MEM_ARB_RR_EN after a prior D grant -> I is served first.
- Memory never asserts mem_valid on a read with TIMEOUT=8 -> x_done pulses 8 cycles after grant; x_rdata=0; err=1 and err remains 1 through later successful accesses.
- rst_n pulled low during DWAIT, then a stale mem_valid arrives in IDLE -> all outputs 0, no d_done, state stays IDLE.
- hlt=1 with i_req pending -> no mem_en. hlt asserted during IWAIT -> the access still completes with i_done.
